// File: rtl/crm_loadable_if.sv
// ---------------------------------------------------------------------------
// crm_loadable_if -- diagnostic load bus of the loadable CRAM store.
//
// Handshake: the master raises ldStart (with ldAdr) to open a load, then
// presents one chunk per ldValid strobe; a chunk is taken only on a cycle
// where ldValid && ldReady, and ldReady depends on the slave's state alone.
// ldAbort discards the load in progress and beats ldValid in the same cycle.
// ldDone pulses one cycle once the assembled word is in memory.
//
// Signals:
//   ldStart  m->s  open a load (ignored while ldBusy)
//   ldAdr    m->s  target address, sampled with ldStart
//   ldValid  m->s  chunk strobe
//   ldData   m->s  chunk payload
//   ldAbort  m->s  discard the load in progress
//   ldReady  s->m  slave is collecting chunks
//   ldBusy   s->m  a load is in progress
//   ldDone   s->m  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface crm_loadable_if #(
   parameter int ADDR_W  = 11,
   parameter int CHUNK_W = 21
);
   logic               ldStart;
   logic [ADDR_W-1:0]  ldAdr;
   logic               ldValid;
   logic [CHUNK_W-1:0] ldData;
   logic               ldAbort;
   logic               ldReady;
   logic               ldBusy;
   logic               ldDone;

   modport master (
      output ldStart, ldAdr, ldValid, ldData, ldAbort,
      input  ldReady, ldBusy, ldDone
   );

   modport slave (
      input  ldStart, ldAdr, ldValid, ldData, ldAbort,
      output ldReady, ldBusy, ldDone
   );
endinterface

// File: rtl/crm_loadable.sv
// ---------------------------------------------------------------------------
// crm_loadable -- parametrised CRAM microword store with a diagnostic
// serial load path.
//
// Holds 2^ADDR_W microwords of WORD_W bits (bit 0 = MSB of the microword,
// which is bit WORD_W-1 of CRAMdata). Every cycle except the load WRITE
// cycle, CRAMdata is reloaded from mem[CRADR]. The load path assembles a
// word from NCHUNK chunks (chunk 0 = most significant) and writes it in a
// single WRITE cycle.
//
// Ports:
//   eboxClk      in   clock, rising edge
//   eboxReset_n  in   asynchronous active-low reset
//   CRADR        in   read address
//   CRAMdata     out  registered microword
//   cramValid    out  CRAMdata holds mem[CRADR of the previous cycle]
//   ld           if   load bus (crm_loadable_if.slave)
//   parityErr    out  sticky read parity error
//   dbgState     out  load FSM state: 0 IDLE, 1 COLLECT, 2 WRITE
//
// Build option: define CRM_PARITY_EN to store an even-parity bit with each
// word and flag read mismatches on parityErr. Without it parityErr is 0.
// ---------------------------------------------------------------------------
module crm_loadable #(
   parameter int    ADDR_W    = 11,
   parameter int    WORD_W    = 84,
   parameter int    CHUNK_W   = 21,
   parameter string INIT_FILE = ""
) (
   input  logic              eboxClk,
   input  logic              eboxReset_n,
   input  logic [ADDR_W-1:0] CRADR,
   output logic [WORD_W-1:0] CRAMdata,
   output logic              cramValid,
   crm_loadable_if.slave     ld,
   output logic              parityErr,
   output logic [1:0]        dbgState
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int NCHUNK = (WORD_W + CHUNK_W - 1) / CHUNK_W;
   localparam int ASM_W  = NCHUNK * CHUNK_W;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
`ifdef CRM_PARITY_EN
   localparam int MEM_W = WORD_W + 1;
`else
   localparam int MEM_W = WORD_W;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ASM_W-1:0]   asm_q;
   logic [ASM_W-1:0]   asm_d;
   logic [ADDR_W-1:0]  adr_q;
   logic               done_q;
   logic [WORD_W-1:0]  cram_q;
   logic               cram_vld_q;
   logic [WORD_W-1:0]  asm_word;
   logic [MEM_W-1:0]   wr_word;
   logic [MEM_W-1:0]   rd_word;
   logic [MEM_W-1:0]   mem_q [DEPTH];

   // The word occupies the top WORD_W bits of the assembly buffer; any
   // padding bits of the last chunk fall off the bottom.
   assign asm_word = asm_q[ASM_W-1 -: WORD_W];

   // Drop the incoming chunk into its slot, counted from the MSB end.
   always_comb begin
      asm_d = asm_q;
      for (int k = 0; k < NCHUNK; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            asm_d[ASM_W-1-k*CHUNK_W -: CHUNK_W] = ld.ldData;
         end
      end
   end

   // Load FSM
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         asm_q   <= '0;
         adr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ld.ldStart) begin
                  state_q <= COLLECT;
                  adr_q   <= ld.ldAdr;
                  cnt_q   <= '0;
                  asm_q   <= '0;
               end
            end
            COLLECT: begin
               // Abort outranks a chunk strobe in the same cycle.
               if (ld.ldAbort) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  asm_q   <= '0;
               end else if (ld.ldValid) begin
                  asm_q <= asm_d;
                  if (cnt_q == LAST_CHUNK) begin
                     state_q <= WRITE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            WRITE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ld.ldReady = (state_q == COLLECT);
   assign ld.ldBusy  = (state_q != IDLE);
   assign ld.ldDone  = done_q;
   assign dbgState   = state_q;

`ifdef CRM_PARITY_EN
   assign wr_word = {asm_word, ^asm_word};
`else
   assign wr_word = asm_word;
`endif

   // Memory array is deliberately not reset.
   always_ff @(posedge eboxClk) begin
      if (state_q == WRITE) begin
         mem_q[adr_q] <= wr_word;
      end
   end

   assign rd_word = mem_q[CRADR];

   // Read register; the WRITE cycle holds CRAMdata and marks it stale.
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         cram_q     <= '0;
         cram_vld_q <= 1'b0;
      end else if (state_q != WRITE) begin
         cram_q     <= rd_word[MEM_W-1 -: WORD_W];
         cram_vld_q <= 1'b1;
      end else begin
         cram_vld_q <= 1'b0;
      end
   end

   assign CRAMdata  = cram_q;
   assign cramValid = cram_vld_q;

`ifdef CRM_PARITY_EN
   logic rd_par_q;
   logic perr_q;

   // Check is made on the registered word, so an error shows one cycle
   // after the bad word appears on CRAMdata; stale (WRITE) cycles skip it.
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         rd_par_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         if (state_q != WRITE) begin
            rd_par_q <= rd_word[0];
         end
         if (cram_vld_q && ((^cram_q) != rd_par_q)) begin
            perr_q <= 1'b1;
         end
      end
   end

   assign parityErr = perr_q;
`else
   assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_crm_loadable.sv
// ---------------------------------------------------------------------------
// tb_crm_loadable -- self-checking bench for crm_loadable.
// Reference model: an associative array of whole words indexed by address,
// updated when a load completes with the plain concatenation of its chunks.
// ---------------------------------------------------------------------------
module tb_crm_loadable;

   localparam int ADDR_W  = 11;
   localparam int WORD_W  = 84;
   localparam int CHUNK_W = 21;
   localparam int NCHUNK  = 4;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;

   typedef logic [CHUNK_W-1:0] chunk_t;

   // ---------------- clock / reset ----------------
   logic              eboxClk = 1'b0;
   logic              eboxReset_n;
   logic [ADDR_W-1:0] CRADR;
   logic [WORD_W-1:0] CRAMdata;
   logic              cramValid;
   logic              parityErr;
   logic [1:0]        dbgState;

   always #5 eboxClk = ~eboxClk;

   crm_loadable_if #(.ADDR_W(ADDR_W), .CHUNK_W(CHUNK_W)) ld_bus ();

   crm_loadable #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W),
      .CHUNK_W(CHUNK_W)
   ) dut (
      .eboxClk    (eboxClk),
      .eboxReset_n(eboxReset_n),
      .CRADR      (CRADR),
      .CRAMdata   (CRAMdata),
      .cramValid  (cramValid),
      .ld         (ld_bus),
      .parityErr  (parityErr),
      .dbgState   (dbgState)
   );

   // ---------------- scoreboard ----------------
   int                n_cmp = 0;
   int                n_err = 0;
   logic [WORD_W-1:0] model_mem [int];
   logic [ADDR_W-1:0] addr_list [$];
   logic [WORD_W-1:0] exp_q [$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected word: chunks concatenated MSB-first, then keep the top WORD_W bits.
   function automatic logic [WORD_W-1:0] pack_chunks(input chunk_t ch [NCHUNK]);
      logic [NCHUNK*CHUNK_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         acc = (acc << CHUNK_W) | (NCHUNK*CHUNK_W)'(ch[i]);
      end
      return acc[NCHUNK*CHUNK_W-1 -: WORD_W];
   endfunction

   function automatic void model_write(input logic [ADDR_W-1:0] adr, input logic [WORD_W-1:0] w);
      if (!model_mem.exists(int'(adr))) addr_list.push_back(adr);
      model_mem[int'(adr)] = w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge eboxClk);
      #1;
   endtask

   task automatic read_chk(input string tag, input logic [ADDR_W-1:0] adr);
      CRADR = adr;
      exp_q.push_back(model_mem[int'(adr)]);
      step();
      check(tag, CRAMdata, exp_q.pop_front());
      check({tag, "_vld"}, cramValid, 1'b1);
   endtask

   task automatic random_chunks(output chunk_t ch [NCHUNK]);
      for (int i = 0; i < NCHUNK; i++) ch[i] = chunk_t'($urandom);
   endtask

   // Full load. 'started' means ldStart was already taken on the previous
   // edge; 'chain' raises the next ldStart in the ldDone cycle.
   task automatic do_load(input logic [ADDR_W-1:0] adr, input chunk_t ch [NCHUNK],
                          input bit started, input int gap_max,
                          input bit chain, input logic [ADDR_W-1:0] next_adr);
      logic [WORD_W-1:0] held;
      if (!started) begin
         ld_bus.ldStart = 1'b1;
         ld_bus.ldAdr   = adr;
         step();
      end
      ld_bus.ldStart = 1'b0;
      check("ld_busy", ld_bus.ldBusy, 1'b1);
      check("ld_ready", ld_bus.ldReady, 1'b1);
      for (int k = 0; k < NCHUNK; k++) begin
         repeat ($urandom_range(0, gap_max)) begin
            ld_bus.ldValid = 1'b0;
            // A stray start during COLLECT must not retarget the load.
            if ($urandom_range(0, 2) == 0) begin
               ld_bus.ldStart = 1'b1;
               ld_bus.ldAdr   = ADDR_W'($urandom);
            end
            CRADR = ADDR_W'($urandom);
            step();
            ld_bus.ldStart = 1'b0;
            check("gap_ready", ld_bus.ldReady, 1'b1);
         end
         ld_bus.ldValid = 1'b1;
         ld_bus.ldData  = ch[k];
         step();
         ld_bus.ldValid = 1'b0;
      end
      check("wr_state", dbgState, S_WRITE);
      check("wr_ready", ld_bus.ldReady, 1'b0);
      check("wr_busy", ld_bus.ldBusy, 1'b1);
      check("wr_done", ld_bus.ldDone, 1'b0);
      held = CRAMdata;
      ld_bus.ldAbort = 1'($urandom_range(0, 1));   // ignored during WRITE
      step();
      ld_bus.ldAbort = 1'b0;
      check("wr_vld", cramValid, 1'b0);
      check("wr_hold", CRAMdata, held);
      check("done_pulse", ld_bus.ldDone, 1'b1);
      check("done_busy", ld_bus.ldBusy, 1'b0);
      model_write(adr, pack_chunks(ch));
      if (chain) begin
         ld_bus.ldStart = 1'b1;
         ld_bus.ldAdr   = next_adr;
      end
      read_chk("raw", adr);
      check("done_clear", ld_bus.ldDone, 1'b0);
      if (chain) check("chain_start", dbgState, S_COLLECT);
      ld_bus.ldStart = 1'b0;
   endtask

   // Partial load of nch chunks, then abort (with a chunk and a start in
   // the same cycle, both of which must lose).
   task automatic abort_load(input logic [ADDR_W-1:0] adr, input int nch);
      ld_bus.ldStart = 1'b1;
      ld_bus.ldAdr   = adr;
      step();
      ld_bus.ldStart = 1'b0;
      for (int k = 0; k < nch; k++) begin
         repeat ($urandom_range(1, 3)) begin
            ld_bus.ldValid = 1'b0;
            step();
         end
         ld_bus.ldValid = 1'b1;
         ld_bus.ldData  = chunk_t'($urandom);
         step();
      end
      ld_bus.ldValid = 1'b1;
      ld_bus.ldAbort = 1'b1;
      ld_bus.ldStart = 1'b1;
      ld_bus.ldAdr   = ~adr;
      step();
      ld_bus.ldValid = 1'b0;
      ld_bus.ldAbort = 1'b0;
      ld_bus.ldStart = 1'b0;
      check("abort_idle", dbgState, S_IDLE);
      check("abort_busy", ld_bus.ldBusy, 1'b0);
      step();
      check("abort_nodone", ld_bus.ldDone, 1'b0);
      check("abort_stay", dbgState, S_IDLE);
      read_chk("abort_rd", adr);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      chunk_t ch [NCHUNK];
      chunk_t ch2 [NCHUNK];

      eboxReset_n    = 1'b0;
      CRADR          = '0;
      ld_bus.ldStart = 1'b0;
      ld_bus.ldAdr   = '0;
      ld_bus.ldValid = 1'b0;
      ld_bus.ldData  = '0;
      ld_bus.ldAbort = 1'b0;

      // Reset state
      repeat (3) @(posedge eboxClk);
      #1;
      check("rst_data", CRAMdata, '0);
      check("rst_vld", cramValid, 1'b0);
      check("rst_busy", ld_bus.ldBusy, 1'b0);
      check("rst_ready", ld_bus.ldReady, 1'b0);
      check("rst_done", ld_bus.ldDone, 1'b0);
      check("rst_state", dbgState, S_IDLE);
      check("rst_perr", parityErr, 1'b0);
      #2 eboxReset_n = 1'b1;
      step();
      check("post_rst_vld", cramValid, 1'b1);

      // Fixed full load to 0x123
      ch[0] = 21'h1ABCD; ch[1] = 21'h02345; ch[2] = 21'h16789; ch[3] = 21'h0F0F0;
      do_load(11'h123, ch, 1'b0, 0, 1'b0, '0);
      check("fixed_word", CRAMdata, {21'h1ABCD, 21'h02345, 21'h16789, 21'h0F0F0});

      // Gapped load of all ones to 0x7FF, then an aborted load there
      for (int i = 0; i < NCHUNK; i++) ch[i] = '1;
      do_load(11'h7FF, ch, 1'b0, 3, 1'b0, '0);
      check("ones_word", CRAMdata, {WORD_W{1'b1}});
      abort_load(11'h7FF, 2);

      // Back-to-back loads 0x000 then 0x001
      random_chunks(ch);
      random_chunks(ch2);
      do_load(11'h000, ch, 1'b0, 1, 1'b1, 11'h001);
      do_load(11'h001, ch2, 1'b1, 1, 1'b0, '0);
      read_chk("b2b_0", 11'h000);

      // Reset during COLLECT after three chunks
      ld_bus.ldStart = 1'b1;
      ld_bus.ldAdr   = 11'h123;
      step();
      ld_bus.ldStart = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ld_bus.ldValid = 1'b1;
         ld_bus.ldData  = chunk_t'($urandom);
         step();
      end
      ld_bus.ldValid = 1'b0;
      #2 eboxReset_n = 1'b0;
      #1;
      check("mid_rst_data", CRAMdata, '0);
      check("mid_rst_vld", cramValid, 1'b0);
      check("mid_rst_busy", ld_bus.ldBusy, 1'b0);
      check("mid_rst_state", dbgState, S_IDLE);
      @(posedge eboxClk);
      #3 eboxReset_n = 1'b1;
      read_chk("mid_rst_rd", 11'h123);
      check("mid_rst_idle", dbgState, S_IDLE);

      // Randomised mix of loads, aborts and read bursts
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               random_chunks(ch);
               do_load(ADDR_W'($urandom), ch, 1'b0, 2, 1'b0, '0);
            end
            1: abort_load(addr_list[$urandom_range(0, addr_list.size() - 1)],
                          $urandom_range(0, NCHUNK - 1));
            default: begin
               repeat ($urandom_range(2, 8)) begin
                  read_chk("rnd_rd", addr_list[$urandom_range(0, addr_list.size() - 1)]);
               end
            end
         endcase
      end

      check("end_perr", parityErr, 1'b0);
      check("end_idle", dbgState, S_IDLE);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
      $fatal(1, "watchdog");
   end

endmodule
